operand_fetch_stage: RTL

- Decode/operand-fetch pipeline stage sitting directly upstream of registers_bank, between IF and EX.
- Splits the incoming 32-bit instruction into fields and drives the bank's rs/rt read addresses.
- Bypasses same-cycle write-back data, because the bank returns the old value on a same-cycle write.
- Tracks in-flight destinations in a scoreboard, stalls on RAW/WAW hazards, and presents registered operands to EX over a valid/ready handshake.

---
 rtl/ofs_pkg.sv | 42 ++++
 rtl/ofs_scoreboard.sv | 40 ++++
 rtl/operand_fetch_stage.sv | 83 ++++++++
 3 files changed

// File: rtl/ofs_pkg.sv
// ofs_pkg: shared opcodes, field positions and instruction decode for the operand fetch stage
package ofs_pkg;
  localparam int REG_IDX_W = 5;
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;
  typedef struct packed {
    logic [5:0] op;
    logic [REG_IDX_W-1:0] rs;
    logic [REG_IDX_W-1:0] rt;
    logic [5:0] funct;
    logic [15:0] imm;
    logic use_rs;
    logic use_rt;
    logic [REG_IDX_W-1:0] dest;
    logic dest_en;
  } dec_t;
  function automatic dec_t decode(input logic [31:0] i);
    dec_t d;
    logic [5:0] op;
    op = i[OP_LSB +: 6];
    d.op = op;
    d.rs = i[RS_LSB +: REG_IDX_W];
    d.rt = i[RT_LSB +: REG_IDX_W];
    d.funct = i[5:0];
    d.imm = i[15:0];
    d.use_rs = op != OP_J && op != OP_JAL;
    d.use_rt = op == OP_RTYPE || op == OP_SW;
    // LW and other I-types fall through to rt as destination
    d.dest = (op == OP_SW || op == OP_J) ? '0 :
             op == OP_RTYPE ? i[RD_LSB +: REG_IDX_W] :
             op == OP_JAL ? 5'd31 : i[RT_LSB +: REG_IDX_W];
    d.dest_en = d.dest != '0;
    return d;
  endfunction
endpackage

// File: rtl/ofs_scoreboard.sv
// ofs_scoreboard: pending-write bits per register and RAW/WAW hazard query
module ofs_scoreboard
  import ofs_pkg::*;
#(
  parameter int REG_N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_en,
  input  logic [REG_IDX_W-1:0] set_idx,
  input  logic                 clr_en,
  input  logic [REG_IDX_W-1:0] clr_idx,
  input  logic                 rel_en,
  input  logic [REG_IDX_W-1:0] rel_idx,
  input  logic                 use_a,
  input  logic [REG_IDX_W-1:0] idx_a,
  input  logic                 use_b,
  input  logic [REG_IDX_W-1:0] idx_b,
  input  logic                 dest_en,
  input  logic [REG_IDX_W-1:0] dest,
  output logic                 hazard
);
  logic [REG_N-1:0] pending, pending_nxt;
  logic busy_a, busy_b, busy_d;
  always_comb begin
    pending_nxt = pending;
    if (clr_en) pending_nxt[clr_idx] = 1'b0;
    if (rel_en) pending_nxt[rel_idx] = 1'b0;
    if (set_en) pending_nxt[set_idx] = 1'b1;
    pending_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pending <= '0;
    else pending <= pending_nxt;
  // a register being written back this cycle is no longer a hazard
  assign busy_a = use_a && pending[idx_a] && !(clr_en && clr_idx == idx_a);
  assign busy_b = use_b && pending[idx_b] && !(clr_en && clr_idx == idx_b);
  assign busy_d = dest_en && pending[dest] && !(clr_en && clr_idx == dest);
  assign hazard = busy_a || busy_b || busy_d;
endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: decode, operand bypass, hazard stall and registered hand-off to EX
module operand_fetch_stage
  import ofs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [DATA_W-1:0]    in_pc,
  output logic [REG_IDX_W-1:0] rf_rs,
  output logic [REG_IDX_W-1:0] rf_rt,
  input  logic [DATA_W-1:0]    rf_data_rs,
  input  logic [DATA_W-1:0]    rf_data_rt,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_pc,
  output logic [DATA_W-1:0]    out_op_a,
  output logic [DATA_W-1:0]    out_op_b,
  output logic [DATA_W-1:0]    out_imm,
  output logic [5:0]           out_opcode,
  output logic [5:0]           out_funct,
  output logic [REG_IDX_W-1:0] out_dest,
  output logic                 out_dest_en
);
  dec_t d;
  logic hazard, issue;
  logic [DATA_W-1:0] op_a, op_b;
  assign d = decode(in_instr);
  assign rf_rs = d.rs;
  assign rf_rt = d.rt;
  // the bank returns the old value on a same-cycle write, so forward wb_data
  assign op_a = d.rs == '0 ? '0 : (wb_en && wb_rd == d.rs) ? wb_data : rf_data_rs;
  assign op_b = d.rt == '0 ? '0 : (wb_en && wb_rd == d.rt) ? wb_data : rf_data_rt;
  assign in_ready = !rst && !flush && !hazard && (!out_valid || out_ready);
  assign issue = in_valid && in_ready;
  ofs_scoreboard #(.REG_N(REG_N)) u_sb (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue && d.dest_en),
    .set_idx (d.dest),
    .clr_en  (wb_en),
    .clr_idx (wb_rd),
    .rel_en  (flush && out_valid && out_dest_en),
    .rel_idx (out_dest),
    .use_a   (d.use_rs),
    .idx_a   (d.rs),
    .use_b   (d.use_rt),
    .idx_b   (d.rt),
    .dest_en (d.dest_en),
    .dest    (d.dest),
    .hazard  (hazard)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_op_a <= '0;
      out_op_b <= '0;
      out_imm <= '0;
      out_opcode <= '0;
      out_funct <= '0;
      out_dest <= '0;
      out_dest_en <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_pc <= in_pc;
      out_op_a <= op_a;
      out_op_b <= op_b;
      out_imm <= {{(DATA_W-16){d.imm[15]}}, d.imm};
      out_opcode <= d.op;
      out_funct <= d.funct;
      out_dest <= d.dest;
      out_dest_en <= d.dest_en;
    end else if (flush || out_ready) out_valid <= 1'b0;
endmodule
